// File: rtl/gcn_transform_engine_if.sv
// Bus between the transform engine and its neighbours: start/status, FM/WM
// read port, and result-row readback toward the aggregation stage.
//   start        : begin a run (sampled only while idle)
//   data_in      : read data, VEC_LEN elements of DATA_WIDTH bits
//   read_row     : result row to read back
//   read_address : FM/WM read address
//   enable_read  : one-cycle read request strobe
//   busy / done  : run in progress / one-cycle completion pulse
//   fm_wm_row    : registered result row, WEIGHT_COLS x DOT_PROD_WIDTH
interface gcn_transform_engine_if #(
  parameter int unsigned VEC_LEN        = 96,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DATA_WIDTH     = 5,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter int unsigned ROW_BW         = 3
);
  logic                                         start;
  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]           data_in;
  logic [ROW_BW-1:0]                            read_row;
  logic [ADDRESS_WIDTH-1:0]                     read_address;
  logic                                         enable_read;
  logic                                         busy;
  logic                                         done;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]   fm_wm_row;

  modport master (
    output start, data_in, read_row,
    input  read_address, enable_read, busy, done, fm_wm_row
  );

  modport slave (
    input  start, data_in, read_row,
    output read_address, enable_read, busy, done, fm_wm_row
  );
endinterface

// File: rtl/gcn_transform_engine.sv
// Multi-lane FM x WM transform engine. Buffers NUM_LANES weight columns per
// pass, then streams every feature row through the shared read port and
// stores NUM_LANES dot products per row into the on-chip result memory.
// Ports: clk, reset (async active-low), bus (slave side of
// gcn_transform_engine_if: start, data_in, read_row in; read_address,
// enable_read, busy, done, fm_wm_row out, all registered).
module gcn_transform_engine #(
  parameter int unsigned VEC_LEN           = 96,
  parameter int unsigned FEATURE_ROWS      = 6,
  parameter int unsigned WEIGHT_COLS       = 3,
  parameter int unsigned DATA_WIDTH        = 5,
  parameter int unsigned DOT_PROD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH     = 13,
  parameter int unsigned NUM_LANES         = 2,
  parameter int unsigned READ_LATENCY      = 1,
  parameter int unsigned WEIGHT_BASE_ADDR  = 0,
  parameter int unsigned FEATURE_BASE_ADDR = 512,
  parameter bit          SIGNED_MODE       = 1'b0,
  parameter bit          SATURATE          = 1'b1,
  parameter int unsigned ROW_BW            = $clog2(FEATURE_ROWS)
) (
  input logic clk,
  input logic reset,
  gcn_transform_engine_if.slave bus
);
  localparam int unsigned ACC_W      = 2 * DATA_WIDTH + $clog2(VEC_LEN) + 1;
  localparam int unsigned NUM_PASSES = (WEIGHT_COLS + NUM_LANES - 1) / NUM_LANES;
  localparam int unsigned LANE_BW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PASS_BW    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int unsigned COL_BW     = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int unsigned WAIT_BW    = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_REQ, S_W_WAIT, S_F_REQ, S_F_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [LANE_BW-1:0] lane_q, lane_d;
  logic [PASS_BW-1:0] pass_q, pass_d;
  logic [ROW_BW-1:0]  row_q, row_d;
  logic [WAIT_BW-1:0] wait_q, wait_d;
  logic               wait_last;
  logic               pass_start;
  int unsigned        col_cur, col_next;

  logic [NUM_LANES-1:0][VEC_LEN-1:0][DATA_WIDTH-1:0]        pad_q;
  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] result_q;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]               row_out_q;
  logic [NUM_LANES-1:0][ACC_W-1:0]                          dot;

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic en_q, en_d, busy_q, busy_d, done_q, done_d;

  // Operand widening to accumulator width, sign- or zero-extended.
  function automatic logic [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED_MODE) return ACC_W'($signed(x));
    return ACC_W'(x);
  endfunction

  // Clamp or wrap a full-precision sum into the stored result width.
  // The unsigned sum never reaches the accumulator MSB, so a signed view is safe.
  function automatic logic [DOT_PROD_WIDTH-1:0] fit(input logic [ACC_W-1:0] acc);
    logic signed [63:0] v, hi, lo;
    v = 64'($signed(acc));
    if (SIGNED_MODE) begin
      hi = (64'sd1 <<< (DOT_PROD_WIDTH - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (DOT_PROD_WIDTH - 1));
    end else begin
      hi = (64'sd1 <<< DOT_PROD_WIDTH) - 64'sd1;
      lo = 64'sd0;
    end
    if (SATURATE && (v > hi))      v = hi;
    else if (SATURATE && (v < lo)) v = lo;
    return DOT_PROD_WIDTH'(v);
  endfunction

  assign wait_last = (wait_q == WAIT_BW'(READ_LATENCY - 1));
  assign col_cur   = 32'(pass_q) * NUM_LANES + 32'(lane_q);
  assign col_next  = 32'(pass_d) * NUM_LANES + 32'(lane_d);
  // Every entry into W_REQ with lane 0 opens a new pass.
  assign pass_start = (state_d == S_W_REQ) && (lane_d == '0);

  // Per-lane dot products of buffered weight column and incoming feature row.
  always_comb begin
    dot = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int i = 0; i < VEC_LEN; i++)
        dot[l] = dot[l] + ext(pad_q[l][i]) * ext(bus.data_in[i]);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and sequencing counters.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pass_d  = pass_q;
    row_d   = row_q;
    wait_d  = '0;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_W_REQ;
        lane_d  = '0;
        pass_d  = '0;
      end
      S_W_REQ: state_d = S_W_WAIT;
      S_W_WAIT: begin
        if (!wait_last) begin
          wait_d = wait_q + 1'b1;
        end else if ((lane_q != LANE_BW'(NUM_LANES - 1)) && (col_cur + 1 < WEIGHT_COLS)) begin
          lane_d  = lane_q + 1'b1;
          state_d = S_W_REQ;
        end else begin
          row_d   = '0;
          state_d = S_F_REQ;
        end
      end
      S_F_REQ: state_d = S_F_WAIT;
      S_F_WAIT: begin
        if (!wait_last) begin
          wait_d = wait_q + 1'b1;
        end else if (row_q != ROW_BW'(FEATURE_ROWS - 1)) begin
          row_d   = row_q + 1'b1;
          state_d = S_F_REQ;
        end else if (pass_q != PASS_BW'(NUM_PASSES - 1)) begin
          pass_d  = pass_q + 1'b1;
          lane_d  = '0;
          state_d = S_W_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    en_d   = 1'b0;
    addr_d = addr_q;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    if (state_d == S_W_REQ) begin
      en_d   = 1'b1;
      addr_d = ADDRESS_WIDTH'(WEIGHT_BASE_ADDR + col_next);
    end else if (state_d == S_F_REQ) begin
      en_d   = 1'b1;
      addr_d = ADDRESS_WIDTH'(FEATURE_BASE_ADDR + 32'(row_d));
    end
  end

  // Counters, weight pad, result memory, readback and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q    <= '0;
      pass_q    <= '0;
      row_q     <= '0;
      wait_q    <= '0;
      pad_q     <= '0;
      result_q  <= '0;
      row_out_q <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pass_q <= pass_d;
      row_q  <= row_d;
      wait_q <= wait_d;
      addr_q <= addr_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (pass_start) pad_q <= '0;
      if ((state_q == S_W_WAIT) && wait_last) pad_q[lane_q] <= bus.data_in;
      if ((state_q == S_F_WAIT) && wait_last) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (32'(pass_q) * NUM_LANES + 32'(l) < WEIGHT_COLS)
            result_q[row_q][COL_BW'(32'(pass_q) * NUM_LANES + 32'(l))] <= fit(dot[l]);
        end
      end
      row_out_q <= (32'(bus.read_row) < FEATURE_ROWS) ? result_q[bus.read_row] : '0;
    end
  end

  assign bus.read_address = addr_q;
  assign bus.enable_read  = en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fm_wm_row    = row_out_q;
endmodule

// File: tb/tb_gcn_transform_engine.sv
// Directed bench for gcn_transform_engine: four configurations (defaults,
// wrapping output, signed 12-bit output, four lanes with latency 3), each
// with a uniform-vector FM/WM memory model behind the shared read port.
module tb_gcn_transform_engine;
  localparam int unsigned VL  = 96;
  localparam int unsigned DW  = 5;
  localparam int unsigned AW  = 13;
  localparam int unsigned FR  = 6;
  localparam int unsigned WC  = 3;
  localparam int unsigned RBW = 3;

  typedef logic [VL-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  int fm_v[4][FR];
  int wm_v[4][4];
  int log0[$];
  int log3[$];
  int dbl0 = 0;
  logic en0_prev = 1'b0;
  logic [AW-1:0] p3a, p3b;

  always #5 clk = ~clk;

  gcn_transform_engine_if #(.VEC_LEN(VL), .WEIGHT_COLS(WC), .DATA_WIDTH(DW),
    .DOT_PROD_WIDTH(16), .ADDRESS_WIDTH(AW), .ROW_BW(RBW)) if0 ();
  gcn_transform_engine_if #(.VEC_LEN(VL), .WEIGHT_COLS(WC), .DATA_WIDTH(DW),
    .DOT_PROD_WIDTH(16), .ADDRESS_WIDTH(AW), .ROW_BW(RBW)) if1 ();
  gcn_transform_engine_if #(.VEC_LEN(VL), .WEIGHT_COLS(WC), .DATA_WIDTH(DW),
    .DOT_PROD_WIDTH(12), .ADDRESS_WIDTH(AW), .ROW_BW(RBW)) if2 ();
  gcn_transform_engine_if #(.VEC_LEN(VL), .WEIGHT_COLS(WC), .DATA_WIDTH(DW),
    .DOT_PROD_WIDTH(16), .ADDRESS_WIDTH(AW), .ROW_BW(RBW)) if3 ();

  gcn_transform_engine u0 (.clk(clk), .reset(reset_n), .bus(if0.slave));
  gcn_transform_engine #(.SATURATE(1'b0)) u1 (.clk(clk), .reset(reset_n), .bus(if1.slave));
  gcn_transform_engine #(.SIGNED_MODE(1'b1), .DOT_PROD_WIDTH(12)) u2 (.clk(clk), .reset(reset_n), .bus(if2.slave));
  gcn_transform_engine #(.NUM_LANES(4), .READ_LATENCY(3)) u3 (.clk(clk), .reset(reset_n), .bus(if3.slave));

  function automatic vec_t mem_data(input int inst, input logic [AW-1:0] addr);
    int a;
    int v;
    logic [DW-1:0] el;
    a = int'(addr);
    v = 0;
    if (a >= 512 && a < 512 + FR) v = fm_v[inst][a-512];
    else if (a < 4)               v = wm_v[inst][a];
    el = DW'(v);
    return {VL{el}};
  endfunction

  // Read port models: latency 1 for u0..u2, latency 3 for u3.
  always @(posedge clk) begin
    if0.data_in <= mem_data(0, if0.read_address);
    if1.data_in <= mem_data(1, if1.read_address);
    if2.data_in <= mem_data(2, if2.read_address);
    p3a <= if3.read_address;
    p3b <= p3a;
    if3.data_in <= mem_data(3, p3b);
  end

  // Request monitors.
  always @(negedge clk) begin
    if (if0.enable_read) begin
      log0.push_back(int'(if0.read_address));
      if (en0_prev) dbl0++;
    end
    en0_prev = if0.enable_read;
    if (if3.enable_read) log3.push_back(int'(if3.read_address));
  end

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: if0.start = v;
      1: if1.start = v;
      2: if2.start = v;
      default: if3.start = v;
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      0: return if0.done;
      1: return if1.done;
      2: return if2.done;
      default: return if3.done;
    endcase
  endfunction

  function automatic logic [47:0] get_row(input int inst);
    case (inst)
      0: return 48'(if0.fm_wm_row);
      1: return 48'(if1.fm_wm_row);
      2: return 48'(if2.fm_wm_row);
      default: return 48'(if3.fm_wm_row);
    endcase
  endfunction

  // Pulse start for one cycle; cyc = cycle index (start edge = 0) of done.
  task automatic start_and_wait(input int inst, output int cyc);
    @(negedge clk); set_start(inst, 1'b1);
    @(negedge clk); set_start(inst, 1'b0);
    cyc = 1;
    while (!get_done(inst) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_row(input int inst, input int r, output logic [47:0] row);
    @(negedge clk);
    case (inst)
      0: if0.read_row = RBW'(r);
      1: if1.read_row = RBW'(r);
      2: if2.read_row = RBW'(r);
      default: if3.read_row = RBW'(r);
    endcase
    @(negedge clk);
    row = get_row(inst);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (if0.read_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", if0.read_address); end
    n_tests++; if (if0.enable_read !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", if0.enable_read); end
    n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
    n_tests++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if0.done); end
    n_tests++; if (if0.fm_wm_row !== '0) begin n_fail++; $display("FAIL reset_row: got %h expected 0", if0.fm_wm_row); end
  endtask

  task automatic test_all_ones;
    int exp_a[15] = '{0, 1, 512, 513, 514, 515, 516, 517, 2, 512, 513, 514, 515, 516, 517};
    int cyc;
    logic [47:0] row;
    for (int r = 0; r < FR; r++) fm_v[0][r] = 1;
    for (int c = 0; c < 4; c++)  wm_v[0][c] = 1;
    log0.delete();
    dbl0 = 0;
    start_and_wait(0, cyc);
    n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL ones_done_cycle: got %0d expected 31", cyc); end
    n_tests++; if (log0.size() !== 15) begin n_fail++; $display("FAIL ones_req_count: got %0d expected 15", log0.size()); end
    for (int i = 0; i < 15; i++) begin
      int got;
      got = (i < log0.size()) ? log0[i] : -1;
      n_tests++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL ones_addr[%0d]: got %0d expected %0d", i, got, exp_a[i]); end
    end
    n_tests++; if (dbl0 !== 0) begin n_fail++; $display("FAIL ones_en_width: got %0d multi-cycle strobes expected 0", dbl0); end
    for (int r = 0; r < FR; r++) begin
      read_row(0, r, row);
      n_tests++; if (row !== 48'({16'd96, 16'd96, 16'd96})) begin n_fail++; $display("FAIL ones_row%0d: got %h expected 006000600060", r, row); end
    end
  endtask

  task automatic test_reset_mid_run;
    int dc = 0;
    int bc = 0;
    int cyc;
    logic [47:0] row;
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (if0.read_address !== AW'(512) || if0.enable_read !== 1'b0 || if0.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_fwait: got addr %0d en %b busy %b expected 512 0 1", if0.read_address, if0.enable_read, if0.busy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++; if (if0.read_address !== '0) begin n_fail++; $display("FAIL midrun_addr: got %0d expected 0", if0.read_address); end
    n_tests++; if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.enable_read !== 1'b0) begin
      n_fail++; $display("FAIL midrun_ctl: got busy %b done %b en %b expected 0 0 0", if0.busy, if0.done, if0.enable_read);
    end
    n_tests++; if (if0.fm_wm_row !== '0) begin n_fail++; $display("FAIL midrun_row: got %h expected 0", if0.fm_wm_row); end
    @(negedge clk); reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (if0.done) dc++;
      if (if0.busy) bc++;
    end
    n_tests++; if (dc !== 0 || bc !== 0) begin n_fail++; $display("FAIL midrun_idle: got done %0d busy %0d cycles expected 0 0", dc, bc); end
    n_tests++; if (if0.fm_wm_row !== '0) begin n_fail++; $display("FAIL midrun_cleared: got %h expected 0", if0.fm_wm_row); end
    start_and_wait(0, cyc);
    n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL midrun_rerun_cycle: got %0d expected 31", cyc); end
    read_row(0, 2, row);
    n_tests++; if (row !== 48'({16'd96, 16'd96, 16'd96})) begin n_fail++; $display("FAIL midrun_rerun_row: got %h expected 006000600060", row); end
  endtask

  task automatic test_saturate;
    int cyc;
    logic [47:0] row;
    for (int r = 0; r < FR; r++) begin fm_v[0][r] = 31; fm_v[1][r] = 31; end
    for (int c = 0; c < 4; c++)  begin wm_v[0][c] = 31; wm_v[1][c] = 31; end
    start_and_wait(0, cyc);
    start_and_wait(1, cyc);
    for (int r = 0; r < FR; r += 5) begin
      read_row(0, r, row);
      n_tests++; if (row !== 48'({16'd65535, 16'd65535, 16'd65535})) begin n_fail++; $display("FAIL sat_row%0d: got %h expected ffffffffffff", r, row); end
      read_row(1, r, row);
      n_tests++; if (row !== 48'({16'd26720, 16'd26720, 16'd26720})) begin n_fail++; $display("FAIL wrap_row%0d: got %h expected 686068606860", r, row); end
    end
  endtask

  task automatic test_signed;
    int cyc;
    logic [47:0] row;
    for (int r = 0; r < FR; r++) fm_v[2][r] = -1;
    for (int c = 0; c < 4; c++)  wm_v[2][c] = c + 1;
    start_and_wait(2, cyc);
    n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL signed_done_cycle: got %0d expected 31", cyc); end
    for (int r = 0; r < FR; r += 3) begin
      read_row(2, r, row);
      n_tests++; if (row !== 48'({12'(-288), 12'(-192), 12'(-96)})) begin n_fail++; $display("FAIL signed_row%0d: got %h expected %h", r, row, 48'({12'(-288), 12'(-192), 12'(-96)})); end
    end
    for (int r = 0; r < FR; r++) fm_v[2][r] = -16;
    for (int c = 0; c < 4; c++)  wm_v[2][c] = -16;
    start_and_wait(2, cyc);
    read_row(2, 4, row);
    n_tests++; if (row !== 48'({12'd2047, 12'd2047, 12'd2047})) begin n_fail++; $display("FAIL signed_sat: got %h expected 7ff7ff7ff", row); end
  endtask

  task automatic test_wide_lanes;
    int exp_a[9] = '{0, 1, 2, 512, 513, 514, 515, 516, 517};
    int cyc;
    int col3 = 0;
    logic [47:0] row;
    for (int r = 0; r < FR; r++) fm_v[3][r] = r;
    for (int c = 0; c < 3; c++)  wm_v[3][c] = c + 1;
    wm_v[3][3] = 7;
    log3.delete();
    start_and_wait(3, cyc);
    n_tests++; if (cyc !== 37) begin n_fail++; $display("FAIL lanes_done_cycle: got %0d expected 37", cyc); end
    n_tests++; if (log3.size() !== 9) begin n_fail++; $display("FAIL lanes_req_count: got %0d expected 9", log3.size()); end
    foreach (log3[i]) if (log3[i] == 3) col3++;
    n_tests++; if (col3 !== 0) begin n_fail++; $display("FAIL lanes_col3: got %0d requests expected 0", col3); end
    for (int i = 0; i < 9; i++) begin
      int got;
      got = (i < log3.size()) ? log3[i] : -1;
      n_tests++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL lanes_addr[%0d]: got %0d expected %0d", i, got, exp_a[i]); end
    end
    for (int r = 0; r < FR; r++) begin
      logic [47:0] e;
      e = 48'({16'(96 * r * 3), 16'(96 * r * 2), 16'(96 * r)});
      read_row(3, r, row);
      n_tests++; if (row !== e) begin n_fail++; $display("FAIL lanes_row%0d: got %h expected %h", r, row, e); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int low = 0;
    logic [47:0] row;
    for (int r = 0; r < FR; r++) fm_v[0][r] = 2;
    for (int c = 0; c < 4; c++)  wm_v[0][c] = 2;
    @(negedge clk); if0.start = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!if0.done && !if0.busy) low++;
    end while (!if0.done && cyc < 300);
    n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 31", cyc); end
    n_tests++; if (low !== 0) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d low cycles expected 0", low); end
    n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b expected 0", if0.busy); end
    @(negedge clk);
    n_tests++; if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart: got busy %b done %b expected 0 0", if0.busy, if0.done); end
    if0.start = 1'b0;
    @(negedge clk);
    n_tests++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b expected 0", if0.busy); end
    start_and_wait(0, cyc);
    n_tests++; if (cyc !== 31) begin n_fail++; $display("FAIL b2b_second_cycle: got %0d expected 31", cyc); end
    read_row(0, 0, row);
    n_tests++; if (row !== 48'({16'd384, 16'd384, 16'd384})) begin n_fail++; $display("FAIL b2b_row: got %h expected 018001800180", row); end
  endtask

  task automatic test_readback_oob;
    logic [47:0] row;
    read_row(0, 6, row);
    n_tests++; if (row !== '0) begin n_fail++; $display("FAIL oob_row6: got %h expected 0", row); end
    read_row(0, 7, row);
    n_tests++; if (row !== '0) begin n_fail++; $display("FAIL oob_row7: got %h expected 0", row); end
    read_row(0, 5, row);
    n_tests++; if (row !== 48'({16'd384, 16'd384, 16'd384})) begin n_fail++; $display("FAIL oob_row5: got %h expected 018001800180", row); end
  endtask

  initial begin
    reset_n = 1'b0;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
    if0.read_row = '0; if1.read_row = '0; if2.read_row = '0; if3.read_row = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_all_ones();
    test_reset_mid_run();
    test_saturate();
    test_signed();
    test_wide_lanes();
    test_back_to_back();
    test_readback_oob();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
